wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf.sv | 99 +++++++++
 tb/tb_wb_grf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// M->W pipeline register plus 31x32 general register file with write counter.
// Optional macro GRF_BYPASS_EN: D-stage reads return the committing W write in the same cycle.
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  M_A3,
    input  logic [31:0] M_RegData,
    input  logic        M_RegWrite,
    input  logic [31:0] M_PC,
    input  logic        W_en,
    input  logic        W_flush,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    output logic [31:0] D_RD1,
    output logic [31:0] D_RD2,
    output logic [4:0]  W_A3,
    output logic [31:0] W_WD,
    output logic        W_RegWrite,
    output logic [31:0] W_PC,
    output logic [15:0] wr_count
);

    // Register 0 has no storage; it is hard-wired to zero on the read side.
    logic [31:0] regs [1:31];
    logic        commit;
    logic [31:0] arr_rd1;
    logic [31:0] arr_rd2;

    assign commit = W_RegWrite && (W_A3 != 5'd0);

    // Flush takes priority over enable; enable low holds the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            W_A3       <= 5'd0;
            W_WD       <= 32'd0;
            W_RegWrite <= 1'b0;
            W_PC       <= 32'd0;
        end else if (W_flush) begin
            W_A3       <= 5'd0;
            W_WD       <= 32'd0;
            W_RegWrite <= 1'b0;
            W_PC       <= 32'd0;
        end else if (W_en) begin
            W_A3       <= M_A3;
            W_WD       <= M_RegData;
            W_RegWrite <= M_RegWrite;
            W_PC       <= M_PC;
        end
    end

    // The write uses the W contents present before this edge, so a reload
    // on the same edge commits the old instruction first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit && (W_A3 == 5'(i))) begin
                    regs[i] <= W_WD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= 16'd0;
        end else if (commit) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    always_comb begin
        arr_rd1 = 32'd0;
        arr_rd2 = 32'd0;
        for (int i = 1; i < 32; i++) begin
            if (D_A1 == 5'(i)) arr_rd1 = regs[i];
            if (D_A2 == 5'(i)) arr_rd2 = regs[i];
        end
    end

`ifdef GRF_BYPASS_EN
    always_comb begin
        D_RD1 = arr_rd1;
        D_RD2 = arr_rd2;
        if (commit && (D_A1 == W_A3)) D_RD1 = W_WD;
        if (commit && (D_A2 == W_A3)) D_RD2 = W_WD;
    end
`else
    // Same-cycle W/D hazards are left to the external forwarding unit.
    always_comb begin
        D_RD1 = arr_rd1;
        D_RD2 = arr_rd2;
    end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: drivers push expected values, a negedge monitor pops and compares.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [4:0]  M_A3;
    logic [31:0] M_RegData;
    logic        M_RegWrite;
    logic [31:0] M_PC;
    logic        W_en;
    logic        W_flush;
    logic [4:0]  D_A1;
    logic [4:0]  D_A2;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic        W_RegWrite;
    logic [31:0] W_PC;
    logic [15:0] wr_count;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_A3  = 0;
    localparam int SEL_WD  = 1;
    localparam int SEL_RW  = 2;
    localparam int SEL_PC  = 3;
    localparam int SEL_CNT = 4;
    localparam int SEL_RD1 = 5;
    localparam int SEL_RD2 = 6;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];

    wb_grf dut (
        .clk        (clk),
        .reset      (reset),
        .M_A3       (M_A3),
        .M_RegData  (M_RegData),
        .M_RegWrite (M_RegWrite),
        .M_PC       (M_PC),
        .W_en       (W_en),
        .W_flush    (W_flush),
        .D_A1       (D_A1),
        .D_A2       (D_A2),
        .D_RD1      (D_RD1),
        .D_RD2      (D_RD2),
        .W_A3       (W_A3),
        .W_WD       (W_WD),
        .W_RegWrite (W_RegWrite),
        .W_PC       (W_PC),
        .wr_count   (wr_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [4:0] a3, input logic [31:0] d,
                           input logic we, input logic [31:0] pc);
        M_A3       = a3;
        M_RegData  = d;
        M_RegWrite = we;
        M_PC       = pc;
    endtask

    task automatic ctl(input logic en, input logic fl);
        W_en    = en;
        W_flush = fl;
    endtask

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_A3:  return {27'd0, W_A3};
            SEL_WD:  return W_WD;
            SEL_RW:  return {31'd0, W_RegWrite};
            SEL_PC:  return W_PC;
            SEL_CNT: return {16'd0, wr_count};
            SEL_RD1: return D_RD1;
            SEL_RD2: return D_RD2;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        int          s;
        logic [31:0] e;
        logic [31:0] a;
        string       n;
        while (exp_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = actual(s);
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    initial begin
        reset = 1'b0;
        drive_m(5'd0, 32'd0, 1'b0, 32'd0);
        ctl(1'b0, 1'b0);
        D_A1 = 5'd0;
        D_A2 = 5'd0;

        // reset state
        tick();
        D_A1 = 5'd5;
        chk(SEL_A3, 32'd0, "rst_w_a3");
        chk(SEL_RW, 32'd0, "rst_w_rw");
        chk(SEL_CNT, 32'd0, "rst_cnt");
        chk(SEL_RD1, 32'd0, "rst_rd1");
        tick();
        reset = 1'b1;

        // basic load, hold, commit
        drive_m(5'd5, 32'h1234, 1'b1, 32'h100);
        ctl(1'b1, 1'b0);
        tick();
        chk(SEL_A3, 32'd5, "load_a3");
        chk(SEL_WD, 32'h1234, "load_wd");
        chk(SEL_RW, 32'd1, "load_rw");
        chk(SEL_PC, 32'h100, "load_pc");
        chk(SEL_CNT, 32'd0, "load_cnt");
        chk(SEL_RD1, BYP ? 32'h1234 : 32'h0, "load_rd1_bypass");
        ctl(1'b0, 1'b0);
        drive_m(5'd6, 32'h5555, 1'b1, 32'h200);
        tick();
        chk(SEL_RD1, 32'h1234, "commit_rd1");
        chk(SEL_CNT, 32'd1, "commit_cnt");
        chk(SEL_A3, 32'd5, "hold_a3");
        chk(SEL_PC, 32'h100, "hold_pc");
        ctl(1'b0, 1'b1);
        tick();
        chk(SEL_RW, 32'd0, "flush_rw");
        chk(SEL_PC, 32'd0, "flush_pc");
        chk(SEL_CNT, 32'd2, "flush_cnt");

        // register 0 write ignored
        drive_m(5'd0, 32'hFFFF_FFFF, 1'b1, 32'h104);
        ctl(1'b1, 1'b0);
        D_A1 = 5'd0;
        tick();
        tick();
        chk(SEL_RD1, 32'd0, "r0_rd1");
        chk(SEL_CNT, 32'd2, "r0_cnt");
        chk(SEL_WD, 32'hFFFF_FFFF, "r0_w_wd");

        // same-cycle W/D conflict
        drive_m(5'd8, 32'hABCD, 1'b1, 32'h108);
        tick();
        ctl(1'b0, 1'b0);
        D_A2 = 5'd8;
        chk(SEL_RD2, BYP ? 32'hABCD : 32'h0, "conflict_rd2_pre");
        chk(SEL_CNT, 32'd2, "conflict_cnt_pre");
        tick();
        chk(SEL_RD2, 32'hABCD, "conflict_rd2_post");
        chk(SEL_CNT, 32'd3, "conflict_cnt_post");
        ctl(1'b0, 1'b1);
        tick();
        chk(SEL_CNT, 32'd4, "conflict_cnt_flush");

        // flush and enable together: bubble wins
        drive_m(5'd3, 32'h3333, 1'b1, 32'h10C);
        ctl(1'b1, 1'b1);
        tick();
        chk(SEL_RW, 32'd0, "flush_en_rw");
        chk(SEL_PC, 32'd0, "flush_en_pc");
        chk(SEL_A3, 32'd0, "flush_en_a3");
        ctl(1'b0, 1'b0);
        D_A1 = 5'd3;
        tick();
        chk(SEL_RD1, 32'd0, "flush_en_r3");
        chk(SEL_CNT, 32'd4, "flush_en_cnt");
        chk(SEL_A3, 32'd0, "hold_bubble_a3");

        // back-to-back: old W commits on the reload edge
        drive_m(5'd9, 32'h99, 1'b1, 32'h110);
        ctl(1'b1, 1'b0);
        tick();
        drive_m(5'd10, 32'hAA, 1'b1, 32'h114);
        D_A1 = 5'd9;
        D_A2 = 5'd10;
        tick();
        chk(SEL_RD1, 32'h99, "b2b_r9");
        chk(SEL_RD2, BYP ? 32'hAA : 32'h0, "b2b_r10_pre");
        chk(SEL_CNT, 32'd5, "b2b_cnt1");
        drive_m(5'd0, 32'd0, 1'b0, 32'd0);
        tick();
        chk(SEL_RD2, 32'hAA, "b2b_r10_post");
        chk(SEL_CNT, 32'd6, "b2b_cnt2");
        chk(SEL_RW, 32'd0, "b2b_rw");

        // asynchronous reset with a pending write in W
        drive_m(5'd12, 32'hC0DE, 1'b1, 32'h118);
        ctl(1'b1, 1'b0);
        tick();
        ctl(1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk(SEL_A3, 32'd0, "arst_a3");
        chk(SEL_WD, 32'd0, "arst_wd");
        chk(SEL_RW, 32'd0, "arst_rw");
        chk(SEL_PC, 32'd0, "arst_pc");
        chk(SEL_CNT, 32'd0, "arst_cnt");
        chk(SEL_RD1, 32'd0, "arst_r9");
        @(negedge clk);
        #1;
        reset = 1'b1;
        D_A1 = 5'd12;
        tick();
        chk(SEL_RD1, 32'd0, "arst_r12_after");
        chk(SEL_CNT, 32'd0, "arst_cnt_after");
        chk(SEL_RW, 32'd0, "arst_rw_after");

        // counter wrap: W holds a write to r7 with enable low
        drive_m(5'd7, 32'h77, 1'b1, 32'h11C);
        ctl(1'b1, 1'b0);
        tick();
        ctl(1'b0, 1'b0);
        D_A1 = 5'd7;
        repeat (65535) tick();
        chk(SEL_CNT, 32'h0000_FFFF, "wrap_ffff");
        tick();
        chk(SEL_CNT, 32'h0000_0000, "wrap_zero");
        chk(SEL_RD1, 32'h77, "wrap_r7");
        ctl(1'b0, 1'b1);
        tick();

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
